// File: rtl/meter_countdown.sv
// rtl/meter_countdown.sv - parking meter paid-time countdown with mm:ss digits, low-time blink and expiry alarm
module meter_countdown #(
    parameter int MAX_SEC   = 5999,
    parameter int RST_SEC   = 0,
    parameter int WARN_SEC  = 180,
    parameter int ALARM_SEC = 10,
    parameter int ADD_A     = 60,
    parameter int ADD_B     = 120,
    parameter int ADD_C     = 300
) (
    input  logic        clk_1Hz,
    input  logic        rst,
    input  logic        run_en,
    input  logic        clr,
    input  logic        add_a,
    input  logic        add_b,
    input  logic        add_c,
    output logic [12:0] time_left,
    output logic [3:0]  min_tens,
    output logic [3:0]  min_ones,
    output logic [3:0]  sec_tens,
    output logic [3:0]  sec_ones,
    output logic [1:0]  state,
    output logic        blink,
    output logic        alarm
);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PAID    = 2'd1,
        LOW     = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam int AW = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;

    localparam state_t RST_STATE = (RST_SEC > WARN_SEC) ? PAID :
                                   (RST_SEC != 0)       ? LOW  : EMPTY;

    function automatic logic [15:0] to_bcd(input logic [12:0] t);
        logic [12:0] m, s, mt, mo, st, so;
        m  = t / 13'd60;
        s  = t - m * 13'd60;
        mt = m / 13'd10;
        mo = m - mt * 13'd10;
        st = s / 13'd10;
        so = s - st * 13'd10;
        return {4'(mt), 4'(mo), 4'(st), 4'(so)};
    endfunction

    logic [12:0]   time_q;
    logic [15:0]   bcd_q;
    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          blink_q, blink_d;

    logic [14:0] dec, credit, sum, nxt;

    // Decrement first, then credit, so a coin at 0 neither loses nor borrows a tick.
    always_comb begin
        dec    = (run_en && time_q != 13'd0) ? {2'b00, time_q} - 15'd1 : {2'b00, time_q};
        credit = (add_a ? 15'(ADD_A) : 15'd0)
               + (add_b ? 15'(ADD_B) : 15'd0)
               + (add_c ? 15'(ADD_C) : 15'd0);
        sum    = dec + credit;
        if (clr)
            nxt = 15'd0;
        else if (sum > 15'(MAX_SEC))
            nxt = 15'(MAX_SEC);
        else
            nxt = sum;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clr) begin
            state_d = EMPTY;
            cnt_d   = '0;
        end else if (nxt > 15'(WARN_SEC)) begin
            state_d = PAID;
            cnt_d   = '0;
        end else if (nxt != 15'd0) begin
            state_d = LOW;
            cnt_d   = '0;
        end else begin
            // Zero reached without clr: only a running meter can have ticked down to it.
            case (state_q)
                PAID, LOW: begin
                    state_d = EXPIRED;
                    cnt_d   = AW'(ALARM_SEC - 1);
                end
                EXPIRED: begin
                    if (cnt_q == '0)
                        state_d = EMPTY;
                    else
                        cnt_d = cnt_q - 1'b1;
                end
                default: state_d = EMPTY;
            endcase
        end
        blink_d = (state_d == LOW || state_d == EXPIRED) ? ~blink_q : 1'b0;
    end

    always_ff @(posedge clk_1Hz or posedge rst) begin
        if (rst) begin
            time_q  <= 13'(RST_SEC);
            bcd_q   <= to_bcd(13'(RST_SEC));
            state_q <= RST_STATE;
            cnt_q   <= '0;
            blink_q <= 1'b0;
        end else begin
            time_q  <= 13'(nxt);
            bcd_q   <= to_bcd(13'(nxt));
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
        end
    end

    assign time_left = time_q;
    assign min_tens  = bcd_q[15:12];
    assign min_ones  = bcd_q[11:8];
    assign sec_tens  = bcd_q[7:4];
    assign sec_ones  = bcd_q[3:0];
    assign state     = state_q;
    assign blink     = blink_q;
    assign alarm     = (state_q == EXPIRED);

endmodule

// File: tb/tb_meter_countdown.sv
// tb/tb_meter_countdown.sv - directed self-checking bench for meter_countdown
module tb_meter_countdown;

    logic        clk_1Hz = 1'b0;
    logic        rst, run_en, clr, add_a, add_b, add_c;
    logic [12:0] time_left;
    logic [3:0]  min_tens, min_ones, sec_tens, sec_ones;
    logic [1:0]  state;
    logic        blink, alarm;

    int pass_cnt  = 0;
    int total_cnt = 0;

    meter_countdown dut (
        .clk_1Hz   (clk_1Hz),
        .rst       (rst),
        .run_en    (run_en),
        .clr       (clr),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_c     (add_c),
        .time_left (time_left),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .state     (state),
        .blink     (blink),
        .alarm     (alarm)
    );

    always #5 clk_1Hz = ~clk_1Hz;

    task automatic tick();
        @(posedge clk_1Hz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Time, digits and state together; digits derived from the expected seconds.
    task automatic chk_t(input string tag, input int t, input int st);
        int m, s;
        m = t / 60;
        s = t % 60;
        chk({tag, ".time"},     16'(time_left), 16'(t));
        chk({tag, ".min_tens"}, 16'(min_tens),  16'(m / 10));
        chk({tag, ".min_ones"}, 16'(min_ones),  16'(m % 10));
        chk({tag, ".sec_tens"}, 16'(sec_tens),  16'(s / 10));
        chk({tag, ".sec_ones"}, 16'(sec_ones),  16'(s % 10));
        chk({tag, ".state"},    16'(state),     16'(st));
    endtask

    initial begin
        rst = 1'b1; run_en = 1'b0; clr = 1'b0;
        add_a = 1'b0; add_b = 1'b0; add_c = 1'b0;
        #12;
        chk_t("reset", 0, 0);
        chk("reset.blink", 16'(blink), 16'd0);
        chk("reset.alarm", 16'(alarm), 16'd0);
        rst = 1'b0;
        tick();
        chk_t("idle", 0, 0);

        // add_b from empty lands in LOW, blink starts toggling
        add_b = 1'b1; run_en = 1'b1;
        tick();
        add_b = 1'b0;
        chk_t("add_b", 120, 2);
        chk("add_b.digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0200);
        chk("add_b.blink", 16'(blink), 16'd1);
        tick();
        chk_t("tick119", 119, 2);
        chk("tick119.blink", 16'(blink), 16'd0);
        tick();
        chk("tick118.blink", 16'(blink), 16'd1);

        // clr beats a simultaneous credit, no alarm from LOW
        clr = 1'b1; add_c = 1'b1;
        tick();
        clr = 1'b0; add_c = 1'b0;
        chk_t("clr_low", 0, 0);
        chk("clr_low.alarm", 16'(alarm), 16'd0);
        chk("clr_low.blink", 16'(blink), 16'd0);

        // simultaneous credits sum, run from 0 loses no tick
        add_a = 1'b1; add_c = 1'b1;
        tick();
        add_a = 1'b0; add_c = 1'b0;
        chk_t("add_ac", 360, 1);
        chk("add_ac.digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0600);
        chk("add_ac.blink", 16'(blink), 16'd0);
        repeat (179) tick();
        chk_t("t181", 181, 1);
        tick();
        chk_t("t180", 180, 2);
        chk("t180.blink", 16'(blink), 16'd1);
        repeat (179) tick();
        chk_t("t1", 1, 2);

        // natural expiry: alarm holds for ALARM_SEC edges even while paused
        tick();
        chk_t("expire", 0, 3);
        chk("expire.alarm", 16'(alarm), 16'd1);
        run_en = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk($sformatf("alarm_hold%0d", i), {14'd0, state}, 16'd3);
            chk($sformatf("alarm_on%0d", i), 16'(alarm), 16'd1);
        end
        tick();
        chk_t("alarm_done", 0, 0);
        chk("alarm_done.alarm", 16'(alarm), 16'd0);
        chk("alarm_done.blink", 16'(blink), 16'd0);

        // credit during alarm cancels it on the same edge
        add_a = 1'b1; run_en = 1'b1;
        tick();
        add_a = 1'b0;
        chk_t("add_a", 60, 2);
        repeat (60) tick();
        chk_t("expire2", 0, 3);
        repeat (3) tick();
        chk("mid_alarm", 16'(alarm), 16'd1);
        add_a = 1'b1;
        tick();
        add_a = 1'b0;
        chk_t("rescue", 60, 2);
        chk("rescue.alarm", 16'(alarm), 16'd0);
        clr = 1'b1; add_c = 1'b1;
        tick();
        clr = 1'b0; add_c = 1'b0;
        chk_t("clr_addc", 0, 0);

        // saturation at 99:59
        run_en = 1'b0; add_a = 1'b1; add_b = 1'b1; add_c = 1'b1;
        repeat (12) tick();
        chk_t("fill5760", 5760, 1);
        tick();
        add_a = 1'b0; add_b = 1'b0; add_c = 1'b0;
        chk_t("sat_all", 5999, 1);
        run_en = 1'b1;
        repeat (9) tick();
        chk_t("t5990", 5990, 1);
        chk("t5990.digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h9950);
        add_c = 1'b1;
        tick();
        add_c = 1'b0;
        chk_t("sat_c", 5999, 1);
        add_a = 1'b1;
        tick();
        add_a = 1'b0;
        chk_t("sat_a_tick", 5999, 1);
        chk("sat.digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h9959);

        // pause holds time
        clr = 1'b1;
        tick();
        clr = 1'b0; run_en = 1'b0; add_c = 1'b1;
        tick();
        add_c = 1'b0;
        chk_t("paused_add", 300, 1);
        run_en = 1'b1;
        repeat (100) tick();
        chk_t("t200", 200, 1);
        run_en = 1'b0;
        repeat (5) tick();
        chk_t("pause", 200, 1);
        chk("pause.digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0320);

        // asynchronous reset between edges
        #3;
        rst = 1'b1;
        #1;
        chk_t("async_rst", 0, 0);
        chk("async_rst.blink", 16'(blink), 16'd0);
        chk("async_rst.alarm", 16'(alarm), 16'd0);
        #2;
        rst = 1'b0;
        add_b = 1'b1;
        tick();
        add_b = 1'b0;
        chk_t("post_rst", 120, 2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
